// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state type, the halt
// instruction encoding and default widths.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    // Instruction word the decoder reports through Ack.
    localparam logic [8:0] HALT_WORD = 9'h1FF;

    localparam int unsigned PC_W_DEFAULT  = 10;
    localparam int unsigned CNT_W_DEFAULT = 16;

endpackage : fetch_sequencer_pkg

// File: rtl/fetch_sequencer_next_pc.sv
// Next-PC selection for a running program: hold on halt, jump on a taken
// branch, otherwise step to the following ROM word (wrapping at the top).
module next_pc_logic
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEFAULT
) (
    input  logic [PC_W-1:0] pc,
    input  logic            ack,
    input  logic            branch_en,
    input  logic            cond_flag,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] next_pc
);

    // Priority mux: halt, then taken branch, then sequential increment.
    always_comb begin
        next_pc = pc + PC_W'(1);
        if (ack) begin
            next_pc = pc;
        end else if (branch_en && cond_flag) begin
            next_pc = target;
        end
    end

endmodule : next_pc_logic

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing unit. Owns the program counter, the
// compare condition flag and the IDLE/RUN/DONE program FSM.
// Optional feature: define FETCH_CYCLE_COUNT_EN to add the CycleCnt
// output, a saturating count of RUN cycles since the last accepted Start.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    input  logic            BranchEn,
    input  logic            SetInst,
    input  logic            CondIn,
    input  logic [PC_W-1:0] Target,
    input  logic            Ack,
    output logic [PC_W-1:0] ProgCtr,
    output logic            RunEn,
    output logic            Done
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] CycleCnt
`endif
);

    if (PC_W < 1) begin : g_bad_pc_w
        $error("fetch_sequencer: PC_W must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("fetch_sequencer: CNT_W must be at least 1");
    end

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] pc_run;
    logic            cond_flag, cond_flag_nxt;
    logic            start_accept;

    next_pc_logic #(
        .PC_W(PC_W)
    ) u_next_pc (
        .pc        (ProgCtr),
        .ack       (Ack),
        .branch_en (BranchEn),
        .cond_flag (cond_flag),
        .target    (Target),
        .next_pc   (pc_run)
    );

    // State, PC and condition flag registers; reset overrides everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            ProgCtr   <= '0;
            cond_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            ProgCtr   <= pc_nxt;
            cond_flag <= cond_flag_nxt;
        end
    end

    // Next-state, next-PC and flag update for the program FSM.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = ProgCtr;
        cond_flag_nxt = cond_flag;
        start_accept  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (Start) begin
                    start_accept  = 1'b1;
                    state_nxt     = RUN;
                    pc_nxt        = StartAddr;
                    cond_flag_nxt = 1'b0;
                end
            end
            RUN: begin
                // The branch decision inside next_pc_logic sees the
                // pre-edge flag, so a simultaneous SetInst only affects
                // later branches; a halt suppresses the flag update.
                pc_nxt = pc_run;
                if (Ack) begin
                    state_nxt = DONE;
                end else if (SetInst) begin
                    cond_flag_nxt = CondIn;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        RunEn = (state == RUN);
        Done  = (state == DONE);
    end

`ifdef FETCH_CYCLE_COUNT_EN
    // Saturating RUN-cycle counter, cleared on reset and on program start.
    always_ff @(posedge Clk) begin
        if (Reset || start_accept) begin
            CycleCnt <= '0;
        end else if (state == RUN && CycleCnt != '1) begin
            CycleCnt <= CycleCnt + CNT_W'(1);
        end
    end
`endif

endmodule : fetch_sequencer
